grant_sequencer: RTL and testbench

- Sequential stage directly downstream of the 5-way fixed-priority arbiter (MSB highest priority, one-hot grant out).
- Samples the arbiter's combinational one-hot grant and locks it into a registered grant. Also produces the encoded channel index.
- Holds the grant until the owning requester releases or the consumer signals done, then enforces an idle gap before the next grant.
- Removes grant glitches and grant switching while a transaction is in flight.

---
 rtl/grant_sequencer_if.sv | 26 ++
 rtl/grant_sequencer.sv | 135 +++++++++++++
 tb/tb_grant_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/grant_sequencer_if.sv
// rtl/grant_sequencer_if.sv - grant/request/done bundle between arbiter side and grant sequencer
interface grant_sequencer_if #(
    parameter int N     = 5,
    parameter int IDX_W = 3
);
    logic [N-1:0]     g;
    logic [N-1:0]     r;
    logic             done;
    logic [N-1:0]     gnt_q;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             err_multi;
    logic             timeout;

    // Arbiter/consumer side: drives requests, grants and done; observes the held grant.
    modport master (
        output g, r, done,
        input  gnt_q, gnt_idx, gnt_valid, err_multi, timeout
    );

    // Sequencer side.
    modport slave (
        input  g, r, done,
        output gnt_q, gnt_idx, gnt_valid, err_multi, timeout
    );
endinterface

// File: rtl/grant_sequencer.sv
// rtl/grant_sequencer.sv - locks a one-hot arbiter grant, holds it per transaction, forces an idle gap (optional GRANT_SEQ_HOLD_TIMEOUT_EN)
module grant_sequencer #(
    parameter int N        = 5,
    parameter int IDX_W    = 3,
    parameter int GAP      = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    grant_sequencer_if.slave  bus
);
    localparam int HW = $clog2(MAX_HOLD);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             exit_normal;
    logic             leave;
`ifdef GRANT_SEQ_HOLD_TIMEOUT_EN
    logic             tmo_q, tmo_d;
    logic             forced;
`endif

    function automatic logic [IDX_W-1:0] encode(input logic [N-1:0] v);
        logic [IDX_W-1:0] e;
        e = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) e = IDX_W'(i);
        end
        return e;
    endfunction

    // Next-state and output decode; g is only looked at while idle.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        err_d       = 1'b0;
        gap_d       = gap_q;
        hold_d      = hold_q;
        exit_normal = 1'b0;
        leave       = 1'b0;
`ifdef GRANT_SEQ_HOLD_TIMEOUT_EN
        tmo_d       = 1'b0;
        forced      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.g != '0) begin
                    if ((bus.g & (bus.g - 1'b1)) == '0) begin
                        grant_d = bus.g;
                        idx_d   = encode(bus.g);
                        valid_d = 1'b1;
                        hold_d  = '0;
                        state_d = S_GRANT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_GRANT: begin
                // Release is judged on the owner's raw request, not on g.
                exit_normal = bus.done || ((bus.r & grant_q) == '0);
                leave       = exit_normal;
`ifdef GRANT_SEQ_HOLD_TIMEOUT_EN
                forced = !exit_normal && (hold_q == HW'(MAX_HOLD - 1));
                tmo_d  = forced;
                leave  = exit_normal || forced;
`endif
                if (hold_q != '1) hold_d = hold_q + 1'b1;
                if (leave) begin
                    grant_d = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    gap_d   = '0;
                    state_d = (GAP > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP - 1)) state_d = S_IDLE;
                else                       gap_d   = gap_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset clears outputs without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            gap_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            gap_q   <= gap_d;
            hold_q  <= hold_d;
        end
    end

`ifdef GRANT_SEQ_HOLD_TIMEOUT_EN
    // Forced-release pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= 1'b0;
        else        tmo_q <= tmo_d;
    end
    assign bus.timeout = tmo_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt_q     = grant_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.err_multi = err_q;
endmodule

// File: tb/tb_grant_sequencer.sv
// tb/tb_grant_sequencer.sv - scoreboard bench for grant_sequencer
module tb_grant_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    grant_sequencer_if #(.N(5), .IDX_W(3)) bus ();

    grant_sequencer #(.N(5), .IDX_W(3), .GAP(1), .MAX_HOLD(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0] gq;
        logic [2:0] idx;
        logic       v;
        logic       e;
        logic       t;
        string      nm;
    } exp_t;

    exp_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs at the falling edge; queue the outputs expected after the next rising edge.
    task automatic cyc(input logic [4:0] gi, input logic [4:0] ri, input logic di,
                       input logic [4:0] eg, input logic [2:0] ei, input logic ev,
                       input logic ee, input logic et, input string nm);
        exp_t x;
        @(negedge clk);
        bus.g    = gi;
        bus.r    = ri;
        bus.done = di;
        x.gq = eg; x.idx = ei; x.v = ev; x.e = ee; x.t = et; x.nm = nm;
        exp_q.push_back(x);
    endtask

    task automatic idle_cycles(input int n, input string nm);
        for (int i = 0; i < n; i++) cyc(5'b0, 5'b0, 1'b0, 5'b0, 3'd0, 1'b0, 1'b0, 1'b0, nm);
    endtask

    task automatic check_zero_now(input string nm);
        checks++;
        if (bus.gnt_q !== 5'b0 || bus.gnt_idx !== 3'd0 || bus.gnt_valid !== 1'b0 ||
            bus.err_multi !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s: got gnt_q=%b idx=%0d valid=%b err=%b tmo=%b, want all zero",
                     nm, bus.gnt_q, bus.gnt_idx, bus.gnt_valid, bus.err_multi, bus.timeout);
        end
    endtask

    // Monitor: sample 2 time units after each rising edge and compare with the queue head.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp_t x;
                x = exp_q.pop_front();
                checks++;
                if (bus.gnt_q !== x.gq || bus.gnt_idx !== x.idx || bus.gnt_valid !== x.v ||
                    bus.err_multi !== x.e || bus.timeout !== x.t) begin
                    errors++;
                    $display("FAIL %s: got gnt_q=%b idx=%0d valid=%b err=%b tmo=%b, want gnt_q=%b idx=%0d valid=%b err=%b tmo=%b",
                             x.nm, bus.gnt_q, bus.gnt_idx, bus.gnt_valid, bus.err_multi, bus.timeout,
                             x.gq, x.idx, x.v, x.e, x.t);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        bus.g    = 5'b0;
        bus.r    = 5'b0;
        bus.done = 1'b0;
        repeat (2) @(negedge clk);
        check_zero_now("reset_state");
        rst_n = 1'b1;
        idle_cycles(2, "idle_after_reset");

        // Highest channel granted, then asynchronous reset in the middle of the grant.
        cyc(5'b10000, 5'b10000, 1'b0, 5'b10000, 3'd4, 1'b1, 1'b0, 1'b0, "t1_grant");
        cyc(5'b10000, 5'b10000, 1'b0, 5'b10000, 3'd4, 1'b1, 1'b0, 1'b0, "t1_hold");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_now("t1_async_reset");
        cyc(5'b0, 5'b0, 1'b0, 5'b0, 3'd0, 1'b0, 1'b0, 1'b0, "t1_reset_held");
        rst_n = 1'b1;
        idle_cycles(1, "t1_after_release");

        // Lower channel keeps its grant while a higher one appears; handover after done + gap.
        cyc(5'b01000, 5'b01000, 1'b0, 5'b01000, 3'd3, 1'b1, 1'b0, 1'b0, "t2_grant");
        cyc(5'b10000, 5'b11000, 1'b0, 5'b01000, 3'd3, 1'b1, 1'b0, 1'b0, "t2_hold_hi_a");
        cyc(5'b10000, 5'b11000, 1'b0, 5'b01000, 3'd3, 1'b1, 1'b0, 1'b0, "t2_hold_hi_b");
        cyc(5'b10000, 5'b11000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0, "t2_done_exit");
        cyc(5'b10000, 5'b11000, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0, "t2_gap");
        cyc(5'b10000, 5'b11000, 1'b0, 5'b10000, 3'd4, 1'b1, 1'b0, 1'b0, "t2_regrant");
        idle_cycles(3, "t2_release");

        // Release by dropping the request, then gap and idle.
        cyc(5'b00001, 5'b00001, 1'b0, 5'b00001, 3'd0, 1'b1, 1'b0, 1'b0, "t3_grant");
        cyc(5'b00001, 5'b00001, 1'b0, 5'b00001, 3'd0, 1'b1, 1'b0, 1'b0, "t3_hold");
        idle_cycles(1, "t3_release");
        idle_cycles(1, "t3_gap");
        idle_cycles(2, "t3_idle");

        // Multi-hot grant flags an error and is ignored; a clean grant follows.
        cyc(5'b00110, 5'b00110, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b1, 1'b0, "t4_err");
        cyc(5'b00000, 5'b00110, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0, "t4_err_clear");
        cyc(5'b00010, 5'b00010, 1'b0, 5'b00010, 3'd1, 1'b1, 1'b0, 1'b0, "t4_grant");
        idle_cycles(3, "t4_release");

        // done and release together give a single exit.
        cyc(5'b00100, 5'b00100, 1'b0, 5'b00100, 3'd2, 1'b1, 1'b0, 1'b0, "t5_grant");
        cyc(5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0, "t5_exit");
        idle_cycles(1, "t5_gap");
        idle_cycles(3, "t5_no_regrant");

        // Long hold on channel 1 with no done and request kept high.
        cyc(5'b00010, 5'b00010, 1'b0, 5'b00010, 3'd1, 1'b1, 1'b0, 1'b0, "t6_grant");
`ifdef GRANT_SEQ_HOLD_TIMEOUT_EN
        for (int i = 1; i < 16; i++)
            cyc(5'b00010, 5'b00010, 1'b0, 5'b00010, 3'd1, 1'b1, 1'b0, 1'b0, "t6_hold");
        cyc(5'b00010, 5'b00010, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b1, "t6_timeout");
        cyc(5'b00010, 5'b00010, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0, "t6_gap");
        cyc(5'b00010, 5'b00010, 1'b0, 5'b00010, 3'd1, 1'b1, 1'b0, 1'b0, "t6_regrant");
`else
        for (int i = 1; i < 42; i++)
            cyc(5'b00010, 5'b00010, 1'b0, 5'b00010, 3'd1, 1'b1, 1'b0, 1'b0, "t6_hold_long");
`endif
        idle_cycles(3, "t6_release");

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
